// File: rtl/uar_rx_arbiter.sv
// Merges NUM_CH receive channels into one tagged valid/ready byte stream; define
// UAR_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module uar_rx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                  clk_16x,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_rdy,
  input  logic [NUM_CH*8-1:0]   ch_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic [CH_W-1:0]       out_ch,
  output logic [NUM_CH-1:0]     ovr_flag,
  input  logic                  ovr_clr
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   rdy_q;
  logic [NUM_CH-1:0]   hold_vld_q, hold_vld_d;
  logic [7:0]          hold_byte_q [NUM_CH];
  logic [7:0]          hold_byte_d [NUM_CH];
  logic [NUM_CH-1:0]   ovr_q, ovr_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_byte_q, out_byte_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;

  logic [NUM_CH-1:0]   cap;
  logic [NUM_CH-1:0]   drain;
  logic [NUM_CH-1:0]   ovr_set;
  logic [CH_W-1:0]     sel;
  logic                found;
  int                  idx;

`ifndef UAR_ARB_FIXED_PRIO_EN
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  // Grant selection looks only at registered holding state.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef UAR_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
`endif
      if (!found && hold_vld_q[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    cap         = ch_rdy & ~rdy_q;
    drain       = '0;
    ovr_set     = '0;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_ch_d    = out_ch_q;
`ifndef UAR_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    if (state_q == LOAD && found) drain[sel] = 1'b1;

    // A capture landing on the channel being drained reloads it instead of overrunning.
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) begin
        if (hold_vld_q[i] && !drain[i]) begin
          ovr_set[i] = 1'b1;
        end else begin
          hold_byte_d[i] = ch_byte[8*i +: 8];
          hold_vld_d[i]  = 1'b1;
        end
      end else if (drain[i]) begin
        hold_vld_d[i] = 1'b0;
      end
    end

    ovr_d = (ovr_clr ? '0 : ovr_q) | ovr_set;

    case (state_q)
      IDLE: begin
        if (|hold_vld_d) state_d = LOAD;
      end
      LOAD: begin
        out_byte_d  = hold_byte_q[sel];
        out_ch_d    = sel;
        out_valid_d = 1'b1;
`ifndef UAR_ARB_FIXED_PRIO_EN
        rr_ptr_d    = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
`endif
        state_d     = WAIT;
      end
      WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= '0;
      hold_vld_q  <= '0;
      ovr_q       <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_byte_q[i] <= '0;
`ifndef UAR_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= ch_rdy;
      hold_vld_q  <= hold_vld_d;
      ovr_q       <= ovr_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_ch_q    <= out_ch_d;
      for (int i = 0; i < NUM_CH; i++) hold_byte_q[i] <= hold_byte_d[i];
`ifndef UAR_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_ch    = out_ch_q;
  assign ovr_flag  = ovr_q;

endmodule

// File: tb/tb_uar_rx_arbiter.sv
// Bench for uar_rx_arbiter: directed cases with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_uar_rx_arbiter;
  localparam int N = 4;

  logic         clk_16x = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] ch_rdy = '0;
  logic [N*8-1:0] ch_byte = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [7:0]   out_byte;
  logic [1:0]   out_ch;
  logic [N-1:0] ovr_flag;
  logic         ovr_clr = 1'b0;

  int vecs = 0;
  int errs = 0;
  logic [9:0] got_q[$];

  uar_rx_arbiter #(.NUM_CH(N), .CH_W(2)) dut (
    .clk_16x(clk_16x), .rst_n(rst_n), .ch_rdy(ch_rdy), .ch_byte(ch_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_ch(out_ch), .ovr_flag(ovr_flag), .ovr_clr(ovr_clr)
  );

  always #5 clk_16x = ~clk_16x;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] got_at(input int k);
    return (got_q.size() > k) ? got_q[k] : 10'h3FF;
  endfunction

  // Behavioural model: holding slots, output register, and arbiter phase flags.
  bit [N-1:0]  m_prev = '0, m_hv = '0, m_ovr = '0, m_set;
  logic [7:0]  m_hb [N] = '{default: 8'h00};
  bit          m_ov = 1'b0, m_load = 1'b0, m_idle;
  logic [7:0]  m_ob = '0;
  int          m_oc = 0, m_rr = 0, m_sel, m_c;

  always @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '0; m_hv = '0; m_ovr = '0; m_ov = 0; m_load = 0;
      m_ob = '0; m_oc = 0; m_rr = 0;
      for (int i = 0; i < N; i++) m_hb[i] = '0;
    end else begin
      m_idle = !m_load && !m_ov;
      m_sel = -1;
      if (m_load) begin
        for (int k = 0; k < N; k++) begin
`ifdef UAR_ARB_FIXED_PRIO_EN
          m_c = k;
`else
          m_c = (m_rr + k) % N;
`endif
          if (m_sel < 0 && m_hv[m_c]) m_sel = m_c;
        end
        if (m_sel >= 0) begin
          m_ob = m_hb[m_sel]; m_oc = m_sel; m_ov = 1'b1;
          m_rr = (m_sel + 1) % N;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      m_set = '0;
      for (int i = 0; i < N; i++) begin
        if (ch_rdy[i] && !m_prev[i]) begin
          if (m_hv[i] && m_sel != i) m_set[i] = 1'b1;
          else begin m_hb[i] = ch_byte[8*i +: 8]; m_hv[i] = 1'b1; end
        end else if (m_sel == i) begin
          m_hv[i] = 1'b0;
        end
      end
      m_ovr = (ovr_clr ? '0 : m_ovr) | m_set;
      m_load = m_idle && (|m_hv);
      m_prev = ch_rdy;
    end
  end

  always @(posedge clk_16x) begin
    #1;
    chk("model_out_valid", 32'(out_valid), 32'(m_ov));
    chk("model_out_byte", 32'(out_byte), 32'(m_ob));
    chk("model_out_ch", 32'(out_ch), 32'(m_oc));
    chk("model_ovr_flag", 32'(ovr_flag), 32'(m_ovr));
  end

  always @(posedge clk_16x)
    if (rst_n && out_valid && out_ready) got_q.push_back({out_ch, out_byte});

  task automatic do_reset();
    @(negedge clk_16x);
    rst_n = 1'b0; ch_rdy = '0; ovr_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk_16x);
    rst_n = 1'b1;
    got_q.delete();
  endtask

  task automatic pulse(input int ch, input logic [7:0] b);
    @(negedge clk_16x);
    ch_byte[8*ch +: 8] = b; ch_rdy[ch] = 1'b1;
    @(negedge clk_16x);
    ch_rdy[ch] = 1'b0;
  endtask

  logic [9:0] exp4 [4] = '{10'h011, 10'h122, 10'h233, 10'h344};
  int len [N] = '{default: 0};

  initial begin
    // 1: reset with all ready lines high, then one grant per channel
    ch_rdy = 4'hF; ch_byte = 32'h44332211;
    #1 chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ovr_flag", 32'(ovr_flag), 0);
    chk("rst_out_byte", 32'(out_byte), 0);
    repeat (2) @(negedge clk_16x);
    rst_n = 1'b1; got_q.delete();
    repeat (30) @(posedge clk_16x);
    chk("t1_grant_count", 32'(got_q.size()), 4);
    for (int k = 0; k < 4; k++) chk("t1_grant", 32'(got_at(k)), 32'(exp4[k]));
    @(negedge clk_16x); ch_rdy = '0;
    repeat (3) @(negedge clk_16x);

    // 2: single byte latency and no recapture while held high
    got_q.delete();
    @(negedge clk_16x); ch_byte[23:16] = 8'hA5; ch_rdy = 4'b0100;
    @(posedge clk_16x); #1 chk("t2_valid_n1", 32'(out_valid), 0);
    @(posedge clk_16x); #1 chk("t2_valid_n2", 32'(out_valid), 1);
    chk("t2_byte", 32'(out_byte), 32'h A5);
    chk("t2_ch", 32'(out_ch), 2);
    repeat (14) @(negedge clk_16x);
    ch_rdy = '0;
    repeat (10) @(posedge clk_16x);
    chk("t2_grant_count", 32'(got_q.size()), 1);

    // 3: round-robin order, then wrap back to ch0
    do_reset();
    @(negedge clk_16x); ch_byte = 32'h44332211; ch_rdy = 4'hF;
    repeat (3) @(negedge clk_16x);
    ch_rdy = '0;
    repeat (20) @(posedge clk_16x);
    for (int k = 0; k < 4; k++) chk("t3_rr", 32'(got_at(k)), 32'(exp4[k]));
    got_q.delete();
    @(negedge clk_16x); ch_byte = 32'hDD0000AA; ch_rdy = 4'b1001;
    @(negedge clk_16x); ch_rdy = '0;
    repeat (15) @(posedge clk_16x);
    chk("t3_wrap0", 32'(got_at(0)), 32'h0AA);
    chk("t3_wrap1", 32'(got_at(1)), 32'h3DD);

    // 4: backpressure and overrun on ch1
    do_reset();
    out_ready = 1'b0;
    pulse(0, 8'h99);
    repeat (4) @(negedge clk_16x);
    pulse(1, 8'h10);
    repeat (3) @(negedge clk_16x);
    pulse(1, 8'h20);
    @(posedge clk_16x); #1 chk("t4_ovr_set", 32'(ovr_flag), 32'b0010);
    chk("t4_out_held", 32'(out_byte), 32'h99);
    @(negedge clk_16x); out_ready = 1'b1;
    repeat (10) @(posedge clk_16x);
    chk("t4_count", 32'(got_q.size()), 2);
    chk("t4_first", 32'(got_at(0)), 32'h099);
    chk("t4_kept", 32'(got_at(1)), 32'h110);
    chk("t4_ovr_sticky", 32'(ovr_flag), 32'b0010);
    @(negedge clk_16x); ovr_clr = 1'b1;
    @(negedge clk_16x); ovr_clr = 1'b0;
    chk("t4_ovr_clr", 32'(ovr_flag), 0);

    // 5: ch1 capture in the same cycle as its drain
    do_reset();
    out_ready = 1'b0;
    pulse(0, 8'h99);
    repeat (3) @(negedge clk_16x);
    pulse(1, 8'h55);
    repeat (3) @(negedge clk_16x);
    out_ready = 1'b1;
    @(posedge clk_16x); @(posedge clk_16x);
    @(negedge clk_16x); ch_byte[15:8] = 8'h66; ch_rdy = 4'b0010;
    @(negedge clk_16x); ch_rdy = '0;
    repeat (10) @(posedge clk_16x);
    chk("t5_count", 32'(got_q.size()), 3);
    chk("t5_g0", 32'(got_at(0)), 32'h099);
    chk("t5_g1", 32'(got_at(1)), 32'h155);
    chk("t5_g2", 32'(got_at(2)), 32'h166);
    chk("t5_no_ovr", 32'(ovr_flag), 0);

    // 6: reset while a byte is waiting and another is held
    do_reset();
    out_ready = 1'b0;
    pulse(2, 8'h77);
    repeat (2) @(negedge clk_16x);
    chk("t6_valid_before", 32'(out_valid), 1);
    pulse(3, 8'h88);
    #3 rst_n = 1'b0;
    #1 chk("t6_valid_async", 32'(out_valid), 0);
    repeat (2) @(negedge clk_16x);
    rst_n = 1'b1; out_ready = 1'b1; got_q.delete();
    repeat (12) @(posedge clk_16x);
    chk("t6_no_grant", 32'(got_q.size()), 0);
    chk("t6_valid_after", 32'(out_valid), 0);

    // Randomized traffic with bursts of backpressure and one mid-run reset
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_16x);
      if (cyc == 1500) begin
        rst_n = 1'b0; ch_rdy = '0;
        for (int i = 0; i < N; i++) len[i] = 0;
      end
      if (cyc == 1502) rst_n = 1'b1;
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (ch_rdy[i]) begin
            if (len[i] == 0) ch_rdy[i] = 1'b0;
            else len[i]--;
          end else if ($urandom_range(0, 19) == 0) begin
            ch_rdy[i] = 1'b1;
            len[i] = $urandom_range(0, 16);
            ch_byte[8*i +: 8] = 8'($urandom);
          end
        end
      end
      out_ready = ($urandom_range(0, 9) < ((cyc % 400) < 200 ? 8 : 2));
      ovr_clr = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk_16x);
    ch_rdy = '0; ovr_clr = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk_16x);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
